rr_arbiter_4: RTL

Four-requester round-robin arbiter that shares one downstream resource, such as an encoder or datapath unit, between four clients. It accepts four request lines and issues a registered one-hot grant plus its 2-bit binary index. It holds the grant until the owner releases the resource or a hold timeout revokes it. It sits between the request sources and the shared resource, and its `gnt_idx` output drives the resource's input-select mux.

---
 rtl/rr_arbiter_4_pkg.sv | 20 ++
 rtl/rr_arbiter_4_pick.sv | 34 +++
 rtl/rr_arbiter_4.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: FSM state
// encodings, requester count and a one-hot helper.
package rr_arbiter_4_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_pick.sv
// Combinational round-robin pick: rotate the request vector so ptr sits at
// bit 0, take the lowest set bit, then add ptr back to get the real index.
module rr_pick_4
    import rr_arbiter_4_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      pick_idx,
    output logic            pick_any
);

    logic [2*NREQ-1:0] w_req_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [1:0]        w_enc;

    // Doubling the vector turns the rotate into a plain part-select.
    assign w_req_dbl = {req, req};
    assign w_rot     = w_req_dbl[ptr +: NREQ];

    always_comb begin
        w_enc = 2'd0;
        casez (w_rot)
            4'b???1: w_enc = 2'd0;
            4'b??10: w_enc = 2'd1;
            4'b?100: w_enc = 2'd2;
            4'b1000: w_enc = 2'd3;
            default: w_enc = 2'd0;
        endcase
    end

    assign pick_any = |req;
    assign pick_idx = w_enc + ptr;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant, owner
// release via done/withdraw, optional hold timeout and a one-cycle bubble.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int TIMEOUT = 16
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      gnt_idx,
    output logic            gnt_valid,
    output logic            to_pulse
);

    localparam int CNT_W_RAW = $clog2(TIMEOUT + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam bit TO_EN     = (TIMEOUT != 0);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [NREQ-1:0]  r_gnt;
    logic [1:0]       r_gnt_idx;
    logic             r_gnt_valid;
    logic             r_to_pulse;

    state_t           w_state_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic [NREQ-1:0]  w_gnt_nxt;
    logic [1:0]       w_gnt_idx_nxt;
    logic             w_gnt_valid_nxt;
    logic             w_to_pulse_nxt;

    logic [1:0]       w_pick_idx;
    logic             w_pick_any;
    logic             w_rel_done;
    logic             w_rel_wd;
    logic             w_rel_to;

    rr_pick_4 u_pick (
        .req      (req),
        .ptr      (r_ptr),
        .pick_idx (w_pick_idx),
        .pick_any (w_pick_any)
    );

    assign w_rel_done = done;
    assign w_rel_wd   = ~req[r_gnt_idx];
    assign w_rel_to   = TO_EN && (r_hold_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_gnt_nxt       = r_gnt;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        w_to_pulse_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_pick_any) begin
                    w_gnt_nxt       = idx_to_onehot(w_pick_idx);
                    w_gnt_idx_nxt   = w_pick_idx;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_cnt_nxt  = '0;
                    w_state_nxt     = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_rel_done || w_rel_wd || w_rel_to) begin
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_ptr_nxt       = r_gnt_idx + 2'd1;
                    w_state_nxt     = S_RELEASE;
                    // Only a pure timeout is flagged; a coincident done or withdraw wins.
                    w_to_pulse_nxt  = w_rel_to && !w_rel_done && !w_rel_wd;
                end else if (r_hold_cnt != CNT_MAX) begin
                    w_hold_cnt_nxt  = r_hold_cnt + CNT_ONE;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_gnt_idx   <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_to_pulse  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_to_pulse  <= w_to_pulse_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign to_pulse  = r_to_pulse;

endmodule
